// File: rtl/sprite_plot_sink.sv
// Sprite plot sink: maps local 16x16 sprite beats to screen coordinates,
// drops transparent and off-screen pixels, buffers survivors in a small
// FIFO and drains them to the VGA adapter over a plot/ready handshake.
// The reset input is named resetn but is asserted high.
module sprite_plot_sink #(
   parameter int                  SPRITE_DIM  = 16,
   parameter int                  SCREEN_W    = 160,
   parameter int                  SCREEN_H    = 120,
   parameter int                  COLOUR_W    = 3,
   parameter logic [COLOUR_W-1:0] TRANSPARENT = '0,
   parameter int                  FIFO_DEPTH  = 4
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                start,
   input  logic [7:0]          origin_x,
   input  logic [6:0]          origin_y,
   input  logic                in_valid,
   input  logic [3:0]          in_x,
   input  logic [3:0]          in_y,
   input  logic [COLOUR_W-1:0] in_colour,
   output logic                in_ready,
   output logic [7:0]          vga_x,
   output logic [6:0]          vga_y,
   output logic [COLOUR_W-1:0] vga_colour,
   output logic                vga_plot,
   input  logic                vga_ready,
   output logic                busy,
   output logic                done
);

   localparam int              PTR_W     = $clog2(FIFO_DEPTH);
   localparam int              CNT_W     = PTR_W + 1;
   localparam int              ENTRY_W   = 8 + 7 + COLOUR_W;
   localparam logic [8:0]      LAST_BEAT = 9'(SPRITE_DIM * SPRITE_DIM - 1);
   localparam logic [8:0]      SCR_W     = 9'(SCREEN_W);
   localparam logic [7:0]      SCR_H     = 8'(SCREEN_H);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCEPT,
      ST_DRAIN,
      ST_DONE
   } state_t;

   state_t             state_q;
   logic [7:0]         origin_x_q;
   logic [6:0]         origin_y_q;
   logic [8:0]         beat_count_q;
   logic               busy_q;
   logic               done_q;

   logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q,  count_d;

   logic               fifo_empty;
   logic               fifo_full;
   logic               accept;
   logic               visible;
   logic               push;
   logic               pop;
   logic [8:0]         sx;
   logic [7:0]         sy;
   logic [ENTRY_W-1:0] push_entry;
   logic [ENTRY_W-1:0] head_entry;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == FULL_CNT);

   // Full FIFO stalls upstream in the same cycle, so a push can never overflow.
   assign in_ready = (state_q == ST_ACCEPT) && !fifo_full;
   assign accept   = in_valid && in_ready;

   // Widened adds keep the carry so off-screen sums are clipped, never wrapped.
   assign sx = {1'b0, origin_x_q} + {5'b0, in_x};
   assign sy = {1'b0, origin_y_q} + {4'b0, in_y};

   assign visible    = (in_colour != TRANSPARENT) && (sx < SCR_W) && (sy < SCR_H);
   assign push       = accept && visible;
   assign pop        = !fifo_empty && vga_ready;
   assign push_entry = {sx[7:0], sy[6:0], in_colour};

   // Head reads as zero when nothing is queued.
   assign head_entry = fifo_empty ? '0 : mem_q[rd_ptr_q];
   assign vga_x      = head_entry[ENTRY_W-1 -: 8];
   assign vga_y      = head_entry[COLOUR_W +: 7];
   assign vga_colour = head_entry[COLOUR_W-1:0];
   assign vga_plot   = !fifo_empty;

   assign busy = busy_q;
   assign done = done_q;

   // Sprite sequencer: origin latch, beat counting and busy/done flags.
   // NOTE: state registers use non-blocking (<=) so every flop samples the
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         state_q      <= ST_IDLE;
         origin_x_q   <= '0;
         origin_y_q   <= '0;
         beat_count_q <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  origin_x_q   <= origin_x;
                  origin_y_q   <= origin_y;
                  beat_count_q <= '0;
                  busy_q       <= 1'b1;
                  state_q      <= ST_ACCEPT;
               end
            end
            ST_ACCEPT: begin
               if (accept) begin
                  beat_count_q <= beat_count_q + 9'd1;
                  if (beat_count_q == LAST_BEAT) begin
                     state_q <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (fifo_empty) begin
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // FIFO pointer and occupancy next-state.
   // NOTE: every signal written here is given a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO pointer and occupancy registers.
   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // FIFO storage write port.
   // NOTE: storage is deliberately not reset; occupancy gates every read, so
   // stale contents are never visible and the array can map to plain RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= push_entry;
      end
   end

endmodule
